// File: rtl/sha3_pkg.sv
`default_nettype none
// sha3_pkg: shared SHA-3 definitions for the digest size encoding and the serializer state type.
package sha3_pkg;

  localparam logic [1:0] SIZE_512 = 2'b00;
  localparam logic [1:0] SIZE_384 = 2'b01;
  localparam logic [1:0] SIZE_256 = 2'b10;
  localparam logic [1:0] SIZE_224 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } ser_state_t;

  // Number of 32-bit words in a digest of the given size.
  function automatic logic [4:0] digest_words(input logic [1:0] out_size);
    case (out_size)
      SIZE_512: digest_words = 5'd16;
      SIZE_384: digest_words = 5'd12;
      SIZE_256: digest_words = 5'd8;
      default:  digest_words = 5'd7;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/digest_serializer.sv
`default_nettype none
// digest_serializer: captures the final Keccak digest slice and streams it as 32-bit words, MSW first.
// Optional macro DIGEST_BYTESWAP_EN byte-reverses every emitted word.
module digest_serializer
  import sha3_pkg::*;
#(
  parameter int DIGEST_MAX_W = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGEST_MAX_W-1:0] state_in,
  input  logic                    state_valid,
  input  logic [1:0]              out_size,
  output logic [31:0]             out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    digest_done
);

  ser_state_t              state;
  logic [DIGEST_MAX_W-1:0] cap;
  logic [4:0]              n_words;
  logic [4:0]              cnt;
  logic [31:0]             word;
  logic [31:0]             word_fmt;
  logic                    at_last;

  assign at_last = (cnt == (n_words - 5'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cap     <= '0;
      n_words <= 5'd0;
      cnt     <= 5'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (state_valid) begin
            cap     <= state_in;
            n_words <= digest_words(out_size);
            cnt     <= 5'd0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (at_last) state <= DONE;
            else         cnt   <= cnt + 5'd1;
          end
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  assign word = cap[DIGEST_MAX_W-1-32*int'(cnt) -: 32];

`ifdef DIGEST_BYTESWAP_EN
  assign word_fmt = {word[7:0], word[15:8], word[23:16], word[31:24]};
`else
  assign word_fmt = word;
`endif

  // Outputs decode directly from registered state, so reset clears them the same cycle.
  assign out_valid   = (state == SEND);
  assign busy        = (state == SEND);
  assign digest_done = (state == DONE);
  assign out_last    = out_valid & at_last;
  assign out_data    = out_valid ? word_fmt : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_digest_serializer.sv
`default_nettype none
// tb_digest_serializer: directed and randomized checks of digest_serializer against a queue-based model.
module tb_digest_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] state_in;
  logic         state_valid;
  logic [1:0]   out_size;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         digest_done;

  int compared   = 0;
  int mismatched = 0;
  bit pat [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  digest_serializer #(.DIGEST_MAX_W(512)) dut (
    .clk         (clk),
    .reset       (reset),
    .state_in    (state_in),
    .state_valid (state_valid),
    .out_size    (out_size),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .digest_done (digest_done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  function automatic int model_words(input logic [1:0] sz);
    int tbl [4] = '{16, 12, 8, 7};
    return tbl[sz];
  endfunction

  function automatic logic [31:0] model_fmt(input logic [31:0] w);
`ifdef DIGEST_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; state_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_data"},  out_data, 32'd0);
    chk({tag, "_last"},  {31'd0, out_last}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, digest_done}, 32'd0);
  endtask

  function automatic logic [511:0] seq_state(input logic [31:0] base);
    logic [511:0] s;
    for (int k = 0; k < 16; k++) s[511-32*k -: 32] = base + 32'(k);
    return s;
  endfunction

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int k = 0; k < 16; k++) s[32*k +: 32] = $urandom;
    return s;
  endfunction

  // mode 0: always ready, 1: fixed stall pattern, 2: random ready
  task automatic run_digest(input logic [511:0] st, input logic [1:0] sz, input int mode,
                            input bit perturb);
    logic [31:0] q [$];
    int  n, beats, cyc;
    bit  acc;
    n = model_words(sz);
    q = {};
    for (int k = 0; k < n; k++) q.push_back(model_fmt(32'(st >> (480 - 32*k))));
    state_in = st; out_size = sz; state_valid = 1'b1; out_ready = (mode == 0);
    step();
    state_valid = 1'b0;
    beats = 0; cyc = 0;
    while (beats < n && cyc < 400) begin
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_data",  out_data, q[beats]);
      chk("beat_last",  {31'd0, out_last}, {31'd0, beats == n - 1});
      chk("beat_busy",  {31'd0, busy}, 32'd1);
      if (perturb && cyc == 2) begin
        state_valid = 1'b1; state_in = rand_state(); out_size = ~sz;
      end else begin
        state_valid = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 5];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      acc = out_ready;
      step();
      cyc++;
      if (acc) beats++;
    end
    state_valid = 1'b0;
    chk("beat_count", 32'(beats), 32'(n));
    if (mode == 0) chk("latency", 32'(cyc + 1), 32'(n + 1));
    chk("end_valid", {31'd0, out_valid}, 32'd0);
    chk("end_data",  out_data, 32'd0);
    chk("end_busy",  {31'd0, busy}, 32'd0);
    chk("end_last",  {31'd0, out_last}, 32'd0);
    chk("end_done",  {31'd0, digest_done}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; state_in = '0; state_valid = 1'b0; out_size = 2'b00; out_ready = 1'b0;
    do_reset();
    check_idle("reset");

    // Full-rate 512-bit digest
    run_digest(seq_state(32'hA000_0000), 2'b00, 0, 1'b0);

    // state_valid in DONE leaves outputs unchanged
    state_in = rand_state(); state_valid = 1'b1;
    step();
    state_valid = 1'b0;
    step();
    chk("done_sv_valid", {31'd0, out_valid}, 32'd0);
    chk("done_sv_done",  {31'd0, digest_done}, 32'd1);
    chk("done_sv_data",  out_data, 32'd0);

    do_reset();
    run_digest(seq_state(32'hA000_0000), 2'b11, 0, 1'b0);
    do_reset();
    run_digest(seq_state(32'hA000_0000), 2'b10, 1, 1'b0);
    do_reset();
    run_digest(seq_state(32'hA000_0000), 2'b10, 2, 1'b1);
    do_reset();
    run_digest(rand_state(), 2'b00, 2, 1'b1);

    // Reset after beat 5 of 16 aborts the transfer
    do_reset();
    state_in = seq_state(32'hA000_0000); out_size = 2'b00; state_valid = 1'b1; out_ready = 1'b1;
    step();
    state_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mid_data", out_data, model_fmt(32'hA000_0005));
    reset = 1'b1;
    step();
    check_idle("mid_reset");

    // Reset together with state_valid: nothing captured
    state_valid = 1'b1;
    step();
    reset = 1'b0; state_valid = 1'b0;
    step();
    check_idle("rst_sv");
    run_digest(seq_state(32'hB000_0000), 2'b00, 0, 1'b0);

    // Byte order of word 0
    do_reset();
    begin
      logic [511:0] s;
      s = rand_state();
      s[511:480] = 32'h1122_3344;
      state_in = s; out_size = 2'b11; state_valid = 1'b1; out_ready = 1'b0;
      step();
      state_valid = 1'b0;
`ifdef DIGEST_BYTESWAP_EN
      chk("byteswap_w0", out_data, 32'h4433_2211);
`else
      chk("byteswap_w0", out_data, 32'h1122_3344);
`endif
      step();
      chk("stall_w0", out_data, model_fmt(32'h1122_3344));
    end

    for (int r = 0; r < 6; r++) begin
      do_reset();
      run_digest(rand_state(), 2'($urandom_range(0, 3)), 2, r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digest_serializer.md
# digest_serializer

Squeeze-side counterpart to the SHA-3 padder. Captures the digest portion of the Keccak state when the final permutation completes. Streams it to the user side as 32-bit words over a valid/ready handshake; the number of words is selected by `out_size`. Sits between `f_permutation` and the AXI/register front end, mirroring how the padder feeds the core with 32-bit words on the absorb side.

## Interface
Parameters:
- `DIGEST_MAX_W`, 512, width of the captured state slice; must be a multiple of 32.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `state_in`  in  512  top 512 bits of the Keccak state; bit 511 is the first digest bit.
- `state_valid`  in  1  single-cycle pulse: `state_in` holds the final digest.
- `out_size`  in  2  00→512, 01→384, 10→256, 11→224 bits; sampled on capture.
- `out_data`  out  32  current digest word.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid & out_ready`.
- `out_last`  out  1  high with the final word of the digest.
- `busy`  out  1  high while in SEND.
- `digest_done`  out  1  sticky; high once all words have been accepted, until reset.

## Operation
- Word count N: 00→16, 01→12, 10→8, 11→7.
- Word k (0-based) is `state_in[511-32k -: 32]`. The first word is the most significant, matching the padder's word order.
- IDLE:
  - All outputs low.
  - On `state_valid`, capture `state_in` and N into internal registers, clear the beat counter, and go to SEND.
- SEND:
  - `out_valid`=1, `out_data`=word[cnt], `out_last`=(cnt==N-1).
  - On accept with cnt<N-1: cnt←cnt+1.
  - On accept with cnt==N-1: go to DONE.
- DONE:
  - `out_valid`=0, `digest_done`=1.
  - Stays here until reset. One hash per reset, consistent with the core.
- `state_valid` is ignored in SEND and DONE. Changes to `out_size` after capture have no effect.
- The beat counter is 5 bits and never wraps past N-1.
- `out_data` is 0 whenever `out_valid`=0.

## Timing
- Every register clears on `reset`: state=IDLE, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `digest_done`=0.
- Reset mid-SEND aborts the transfer. A new `state_valid` afterwards restarts from word 0.
- `state_valid` at cycle T → `out_valid`=1 with word 0 at T+1.
- Accept at cycle T → next word presented at T+1. Full throughput is one word per cycle.
- With `out_ready`=0, `out_data`/`out_last` stay stable and `out_valid` stays high. No retraction.
- Last accept at T → `out_valid`=0, `busy`=0, `digest_done`=1 at T+1.
- Simultaneous `reset` and `state_valid`: reset wins and nothing is captured.
- Total latency at full ready: N+1 cycles from `state_valid` to `digest_done`.

## Configuration
- `DIGEST_BYTESWAP_EN`:
  - Defined: each output word is byte-reversed (`out_data`={b0,b1,b2,b3} of the selected word), giving little-endian layout for software.
  - Undefined: words are emitted exactly as sliced.
- `out_last`, `out_valid` and the word count are unaffected by the macro.

## Structure
- Shared package `sha3_pkg`:
  - `out_size` encoding constants (`SIZE_512`..`SIZE_224`).
  - function `digest_words(out_size)` returning N.
  - state enum `ser_state_t {IDLE, SEND, DONE}`.
- No sub-module. A single module holds the capture register, the counter and the FSM; the word mux is an indexed part-select.

## Test plan
- Full-rate 512: `out_size`=00, word k=32'hA000_0000+k, `out_ready`=1, pulse `state_valid` → 16 consecutive beats A0000000..A000000F, `out_last` on beat 16 only, `digest_done`=1 the cycle after.
- 224: `out_size`=11, same state → 7 beats ending A0000006 with `out_last`; no 8th beat; `digest_done` at cycle T+8.
- Backpressure: `out_size`=10, `out_ready` pattern 0,1,0,0,1,… → 8 words in order, `out_data` stable while stalled, no word lost or duplicated.
- Ignored inputs: second `state_valid` with different data mid-SEND, and `out_size` changed mid-SEND → stream continues from original capture with original N; in DONE, `state_valid` leaves outputs unchanged.
- Reset mid-operation: reset after beat 5 of 16 → next cycle all outputs 0; new `state_valid` with word k=32'hB000_0000+k → first beat B0000000.
- With `DIGEST_BYTESWAP_EN`: word 0 = 32'h11223344 → `out_data`=32'h44332211; without the macro → 32'h11223344.
